// File: rtl/oldland_dbus_ctrl.sv
// Data-bus controller: decodes a CPU data request, runs one bus transfer
// with a wait-cycle timeout, and answers with a single ack or error pulse.
module oldland_dbus_ctrl #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFF0_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // CPU side
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_bytesel,
    input  logic        d_wr_en,
    input  logic [31:0] d_wr_val,
    input  logic        d_access,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_error,
    // Bus side
    output logic [29:0] b_addr,
    output logic [3:0]  b_bytesel,
    output logic        b_wr_en,
    output logic [31:0] b_wr_val,
    output logic        b_cs,
    input  logic [31:0] b_rdata,
    input  logic        b_ready,
    input  logic        b_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [29:0]    b_addr_q, b_addr_d;
    logic [3:0]     b_bytesel_q, b_bytesel_d;
    logic           b_wr_en_q, b_wr_en_d;
    logic [31:0]    b_wr_val_q, b_wr_val_d;
    logic           b_cs_q, b_cs_d;
    logic [31:0]    d_data_q, d_data_d;
    logic           d_ack_q, d_ack_d;
    logic           d_error_q, d_error_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           hit;

    assign hit = ((d_addr & ADDR_MASK) == ADDR_BASE);

    // Next-state, request latching, wait counting and registered output decode.
    always_comb begin
        state_d     = state_q;
        b_addr_d    = b_addr_q;
        b_bytesel_d = b_bytesel_q;
        b_wr_en_d   = b_wr_en_q;
        b_wr_val_d  = b_wr_val_q;
        d_data_d    = d_data_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        b_cs_d      = 1'b0;
        d_ack_d     = 1'b0;
        d_error_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (d_access) begin
                    if (hit && (d_bytesel != 4'b0000)) begin
                        b_addr_d    = d_addr[31:2];
                        b_bytesel_d = d_bytesel;
                        b_wr_en_d   = d_wr_en;
                        b_wr_val_d  = d_wr_val;
                        cnt_d       = '0;
                        state_d     = ST_BUS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_BUS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (b_err) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (b_ready) begin
                    if (!b_wr_en_q) begin
                        d_data_d = b_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are flops loaded from the state being entered.
        b_cs_d    = (state_d == ST_BUS);
        d_ack_d   = (state_d == ST_RESP) && !err_d;
        d_error_d = (state_d == ST_RESP) && err_d;
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            b_addr_q    <= '0;
            b_bytesel_q <= '0;
            b_wr_en_q   <= 1'b0;
            b_wr_val_q  <= '0;
            b_cs_q      <= 1'b0;
            d_data_q    <= '0;
            d_ack_q     <= 1'b0;
            d_error_q   <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_addr_q    <= b_addr_d;
            b_bytesel_q <= b_bytesel_d;
            b_wr_en_q   <= b_wr_en_d;
            b_wr_val_q  <= b_wr_val_d;
            b_cs_q      <= b_cs_d;
            d_data_q    <= d_data_d;
            d_ack_q     <= d_ack_d;
            d_error_q   <= d_error_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign b_addr    = b_addr_q;
    assign b_bytesel = b_bytesel_q;
    assign b_wr_en   = b_wr_en_q;
    assign b_wr_val  = b_wr_val_q;
    assign b_cs      = b_cs_q;
    assign d_data    = d_data_q;
    assign d_ack     = d_ack_q;
    assign d_error   = d_error_q;

endmodule

// File: tb/tb_oldland_dbus_ctrl.sv
// Directed bench for oldland_dbus_ctrl: table of single transactions plus
// hand-written reset-mid-bus and back-to-back sequences.
module tb_oldland_dbus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] d_addr;
    logic [3:0]  d_bytesel;
    logic        d_wr_en;
    logic [31:0] d_wr_val;
    logic        d_access;
    logic [31:0] d_data;
    logic        d_ack;
    logic        d_error;
    logic [29:0] b_addr;
    logic [3:0]  b_bytesel;
    logic        b_wr_en;
    logic [31:0] b_wr_val;
    logic        b_cs;
    logic [31:0] b_rdata;
    logic        b_ready;
    logic        b_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    oldland_dbus_ctrl #(
        .ADDR_BASE (32'h0000_0000),
        .ADDR_MASK (32'hFFF0_0000),
        .TIMEOUT   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d_addr    (d_addr),
        .d_bytesel (d_bytesel),
        .d_wr_en   (d_wr_en),
        .d_wr_val  (d_wr_val),
        .d_access  (d_access),
        .d_data    (d_data),
        .d_ack     (d_ack),
        .d_error   (d_error),
        .b_addr    (b_addr),
        .b_bytesel (b_bytesel),
        .b_wr_en   (b_wr_en),
        .b_wr_val  (b_wr_val),
        .b_cs      (b_cs),
        .b_rdata   (b_rdata),
        .b_ready   (b_ready),
        .b_err     (b_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  bytesel;
        logic        wr_en;
        logic [31:0] wr_val;
        int          resp_at;   // bus cycle on which the slave answers, 0 = never
        logic        resp_rdy;
        logic        resp_err;
        logic [31:0] rdata;
        int          exp_bus;
        int          exp_ack;
        int          exp_err;
        logic [29:0] exp_baddr;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request, emulate the slave, and check the response.
    task automatic run_txn(input vec_t v, input string name, input bit release_rst);
        int  bus       = 0;
        int  acks      = 0;
        int  errs      = 0;
        int  both      = 0;
        int  unstable  = 0;
        int  pulse_idx = -1;
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        d_addr    = v.addr;
        d_bytesel = v.bytesel;
        d_wr_en   = v.wr_en;
        d_wr_val  = v.wr_val;
        d_access  = 1'b1;
        b_ready   = 1'b0;
        b_err     = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                d_addr    = ~v.addr;
                d_bytesel = ~v.bytesel;
                d_wr_en   = ~v.wr_en;
                d_wr_val  = ~v.wr_val;
            end
            b_ready = 1'b0;
            b_err   = 1'b0;
            b_rdata = $urandom;
            if (b_cs) begin
                bus++;
                if (b_addr !== v.exp_baddr || b_bytesel !== v.bytesel ||
                    b_wr_en !== v.wr_en || b_wr_val !== v.wr_val)
                    unstable++;
                if (bus == v.resp_at) begin
                    b_ready = v.resp_rdy;
                    b_err   = v.resp_err;
                    b_rdata = v.rdata;
                end
            end
            if (d_ack) acks++;
            if (d_error) errs++;
            if (d_ack && d_error) both++;
            if ((d_ack || d_error) && pulse_idx < 0) begin
                pulse_idx = c;
                d_access  = 1'b0;
            end
            if (pulse_idx > 0 && c >= pulse_idx + 3) break;
        end
        d_access = 1'b0;
        check({name, " bus_cycles"}, 32'(bus), 32'(v.exp_bus));
        check({name, " ack_count"}, 32'(acks), 32'(v.exp_ack));
        check({name, " err_count"}, 32'(errs), 32'(v.exp_err));
        check({name, " pulse_latency"}, 32'(pulse_idx), 32'(v.exp_bus + 1));
        check({name, " bus_stable"}, 32'(unstable), 32'd0);
        check({name, " ack_and_err"}, 32'(both), 32'd0);
        check({name, " d_data"}, d_data, v.exp_data);
    endtask

    initial begin
        int bus;
        int acks;
        int errs;
        int s1;
        int s2;
        logic prev_cs;

        //          addr          bsel    we    wr_val         at  rdy   err   rdata          bus ack err baddr          data
        vecs[0]  = '{32'h0000_1004, 4'hF,  1'b0, 32'h1111_1111, 1,  1'b1, 1'b0, 32'hDEAD_BEEF, 1,  1,  0,  30'h0000_0401, 32'hDEAD_BEEF};
        vecs[1]  = '{32'h0000_0008, 4'h4,  1'b1, 32'h00AB_0000, 4,  1'b1, 1'b0, 32'h5555_5555, 4,  1,  0,  30'h0000_0002, 32'hDEAD_BEEF};
        vecs[2]  = '{32'h8000_0000, 4'hF,  1'b0, 32'h0,         1,  1'b1, 1'b0, 32'h0,         0,  0,  1,  30'h0,         32'hDEAD_BEEF};
        vecs[3]  = '{32'h0000_0010, 4'h0,  1'b0, 32'h0,         1,  1'b1, 1'b0, 32'h0,         0,  0,  1,  30'h0,         32'hDEAD_BEEF};
        vecs[4]  = '{32'h0000_0020, 4'hF,  1'b0, 32'h2222_2222, 0,  1'b0, 1'b0, 32'h0,         16, 0,  1,  30'h0000_0008, 32'hDEAD_BEEF};
        vecs[5]  = '{32'h0000_0024, 4'hF,  1'b0, 32'h3333_3333, 2,  1'b1, 1'b1, 32'hCAFE_F00D, 2,  0,  1,  30'h0000_0009, 32'hDEAD_BEEF};
        vecs[6]  = '{32'h0000_0028, 4'h3,  1'b0, 32'h4444_4444, 1,  1'b0, 1'b1, 32'hBAD0_BAD0, 1,  0,  1,  30'h0000_000A, 32'hDEAD_BEEF};
        vecs[7]  = '{32'h0000_0030, 4'hF,  1'b0, 32'h6666_6666, 16, 1'b1, 1'b0, 32'h1234_5678, 16, 1,  0,  30'h0000_000C, 32'h1234_5678};
        vecs[8]  = '{32'h000F_FFFF, 4'h3,  1'b0, 32'h7777_7777, 1,  1'b1, 1'b0, 32'hA5A5_5A5A, 1,  1,  0,  30'h0003_FFFF, 32'hA5A5_5A5A};
        vecs[9]  = '{32'h0010_0000, 4'hF,  1'b0, 32'h0,         1,  1'b1, 1'b0, 32'h0,         0,  0,  1,  30'h0,         32'hA5A5_5A5A};
        vecs[10] = '{32'h0000_0100, 4'hF,  1'b1, 32'hFEED_FACE, 1,  1'b1, 1'b0, 32'h9999_9999, 1,  1,  0,  30'h0000_0040, 32'hA5A5_5A5A};

        rst_n     = 1'b0;
        d_addr    = '0;
        d_bytesel = '0;
        d_wr_en   = 1'b0;
        d_wr_val  = '0;
        d_access  = 1'b0;
        b_rdata   = '0;
        b_ready   = 1'b0;
        b_err     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset b_cs", 32'(b_cs), 32'd0);
        check("reset d_ack", 32'(d_ack), 32'd0);
        check("reset d_error", 32'(d_error), 32'd0);
        check("reset b_addr", 32'(b_addr), 32'd0);
        check("reset b_bytesel", 32'(b_bytesel), 32'd0);
        check("reset b_wr_en", 32'(b_wr_en), 32'd0);
        check("reset b_wr_val", b_wr_val, 32'd0);
        check("reset d_data", d_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i), 1'b0);
        end

        // Reset on the third bus cycle of a silent transfer.
        @(negedge clk);
        d_addr    = 32'h0000_0040;
        d_bytesel = 4'hF;
        d_wr_en   = 1'b1;
        d_wr_val  = 32'h0BAD_0BAD;
        d_access  = 1'b1;
        bus = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (b_cs) bus++;
            if (bus == 3) break;
        end
        check("midbus reached", 32'(bus), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midbus b_cs async", 32'(b_cs), 32'd0);
        check("midbus b_addr", 32'(b_addr), 32'd0);
        check("midbus b_wr_en", 32'(b_wr_en), 32'd0);
        check("midbus d_data", d_data, 32'd0);
        acks = 0;
        errs = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (d_ack) acks++;
            if (d_error) errs++;
            if (b_cs) errs++;
        end
        check("midbus no pulses", 32'(acks + errs), 32'd0);
        run_txn(vecs[0], "after_reset", 1'b1);

        // Back-to-back reads with d_access held high.
        @(negedge clk);
        d_addr    = 32'h0000_0200;
        d_bytesel = 4'hF;
        d_wr_en   = 1'b0;
        d_wr_val  = '0;
        d_access  = 1'b1;
        bus = 0; acks = 0; s1 = -1; s2 = -1;
        prev_cs = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            b_ready = 1'b0;
            if (b_cs) begin
                bus++;
                if (!prev_cs) begin
                    if (s1 < 0) s1 = c;
                    else if (s2 < 0) s2 = c;
                end
                b_ready = 1'b1;
                b_rdata = (bus == 1) ? 32'h1111_AAAA : 32'h2222_BBBB;
            end
            prev_cs = b_cs;
            if (d_ack) begin
                acks++;
                if (acks == 2) d_access = 1'b0;
            end
        end
        d_access = 1'b0;
        b_ready  = 1'b0;
        check("b2b ack_count", 32'(acks), 32'd2);
        check("b2b bus_cycles", 32'(bus), 32'd2);
        check("b2b first_start", 32'(s1), 32'd1);
        check("b2b second_start", 32'(s2), 32'd5);
        check("b2b d_data", d_data, 32'h2222_BBBB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
